// File: rtl/p2s_arbiter.sv
// rtl/p2s_arbiter.sv - two-channel arbiter sharing one P2S serializer
// Optional shadow-word refresh enabled by defining P2S_ARB_REFRESH_EN.
module p2s_arbiter #(
  parameter int DATA_BITS    = 64,
  parameter int TIMEOUT_BITS = 4,
  parameter int PRIO_FIXED   = 0
`ifdef P2S_ARB_REFRESH_EN
  ,
  parameter int REFRESH_BITS = 20
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ack1,
  input  logic                 p2s_idle,
  output logic                 p2s_start,
  output logic [DATA_BITS-1:0] p2s_data,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, KICK, WAIT_BUSY, WAIT_DONE, ACK} state_t;

  localparam logic [TIMEOUT_BITS-1:0] TMAX = '1;

  state_t                  state;
  logic                    rr;
  logic [TIMEOUT_BITS-1:0] timer;
  logic                    pick1;

`ifdef P2S_ARB_REFRESH_EN
  logic [REFRESH_BITS-1:0] rcnt;
  logic                    rpend;
  logic                    svalid;
  logic                    rxfer;
  logic [DATA_BITS-1:0]    shadow;
`endif

  always_comb begin
    if (PRIO_FIXED != 0)
      pick1 = !req0;
    else if (req0 && req1)
      pick1 = rr;
    else
      pick1 = req1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      timer     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      p2s_start <= 1'b0;
      p2s_data  <= '0;
      grant     <= 2'b00;
      busy      <= 1'b0;
      err       <= 1'b0;
`ifdef P2S_ARB_REFRESH_EN
      rcnt      <= '0;
      rpend     <= 1'b0;
      svalid    <= 1'b0;
      rxfer     <= 1'b0;
      shadow    <= '0;
`endif
    end else begin
      p2s_start <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (p2s_idle && (req0 || req1)) begin
            p2s_data  <= pick1 ? data1 : data0;
            grant     <= pick1 ? 2'b10 : 2'b01;
            p2s_start <= 1'b1;
            busy      <= 1'b1;
            state     <= KICK;
          end
`ifdef P2S_ARB_REFRESH_EN
          else if (p2s_idle && rpend && svalid) begin
            // ownerless resend of the last good word; grant stays 00
            p2s_data  <= shadow;
            rxfer     <= 1'b1;
            p2s_start <= 1'b1;
            busy      <= 1'b1;
            state     <= KICK;
          end
`endif
        end
        KICK: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!p2s_idle) begin
            state <= WAIT_DONE;
          end else if (timer + 1'b1 == TMAX) begin
            err   <= 1'b1;
            grant <= 2'b00;
            busy  <= 1'b0;
            timer <= '0;
            state <= IDLE;
`ifdef P2S_ARB_REFRESH_EN
            if (rxfer) begin
              rxfer <= 1'b0;
              rpend <= 1'b0;
            end else
`endif
            rr <= ~rr;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (p2s_idle) begin
`ifdef P2S_ARB_REFRESH_EN
            if (rxfer) begin
              rxfer <= 1'b0;
              rpend <= 1'b0;
              busy  <= 1'b0;
              state <= IDLE;
            end else
`endif
            begin
              ack0  <= grant[0];
              ack1  <= grant[1];
              grant <= 2'b00;
              rr    <= ~rr;
              state <= ACK;
`ifdef P2S_ARB_REFRESH_EN
              shadow <= p2s_data;
              svalid <= 1'b1;
`endif
            end
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef P2S_ARB_REFRESH_EN
      // placed after the FSM so a wrap on the completion edge is not lost
      rcnt <= rcnt + 1'b1;
      if ((&rcnt) && svalid)
        rpend <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_p2s_arbiter.sv
// tb/tb_p2s_arbiter.sv - self-checking bench for p2s_arbiter
// Instance a is round-robin, instance b is fixed priority; both share requesters.
module tb_p2s_arbiter;

  localparam logic [63:0] WA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WB = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] WC = 64'h5555_AAAA_0F0F_F0F0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [63:0] data0 = '0;
  logic [63:0] data1 = '0;

  logic        ack0_a, ack1_a, p2s_start_a, busy_a, err_a;
  logic        ack0_b, ack1_b, p2s_start_b, busy_b, err_b;
  logic [63:0] p2s_data_a, p2s_data_b;
  logic [1:0]  grant_a, grant_b;

  logic [1:0]  sidle = 2'b11;
  int          scnt[2];
  bit          respond = 1'b1;
  int          shift_len = 4;
  int          qa[$];
  int          qb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  wire [1:0] st = {p2s_start_b, p2s_start_a};

  p2s_arbiter #(.DATA_BITS(64), .TIMEOUT_BITS(4), .PRIO_FIXED(0)) u_a (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0_a),
    .req1(req1), .data1(data1), .ack1(ack1_a),
    .p2s_idle(sidle[0]), .p2s_start(p2s_start_a), .p2s_data(p2s_data_a),
    .grant(grant_a), .busy(busy_a), .err(err_a)
  );

  p2s_arbiter #(.DATA_BITS(64), .TIMEOUT_BITS(4), .PRIO_FIXED(1)) u_b (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0_b),
    .req1(req1), .data1(data1), .ack1(ack1_b),
    .p2s_idle(sidle[1]), .p2s_start(p2s_start_b), .p2s_data(p2s_data_b),
    .grant(grant_b), .busy(busy_b), .err(err_b)
  );

  always #5 clk = ~clk;

  // serializer model: EN drops the negedge Start is seen, returns shift_len cycles later
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sidle[i] = 1'b1;
        scnt[i]  = 0;
      end else if (st[i] && respond) begin
        sidle[i] = 1'b0;
        scnt[i]  = shift_len;
      end else if (scnt[i] > 0) begin
        scnt[i]--;
        if (scnt[i] == 0) sidle[i] = 1'b1;
      end
    end
    if (ack0_a) qa.push_back(0);
    if (ack1_a) qa.push_back(1);
    if (ack0_b) qb.push_back(0);
    if (ack1_b) qb.push_back(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    respond = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  initial begin
    int t, t_idle, t_ack, nack;
    bit gok;

    // reset values
    do_reset();
    chk("rst_ctl", {ack0_a, ack1_a, p2s_start_a, grant_a, busy_a, err_a}, 0);
    chk("rst_data", p2s_data_a, 0);

    // single channel-0 transfer with a 64-cycle shift
    shift_len = 64;
    data0 = WA;
    req0 = 1'b1;
    tick();
    chk("t1_grant", grant_a, 2'b01);
    chk("t1_start", p2s_start_a, 1);
    chk("t1_data", p2s_data_a, WA);
    t = 0; t_idle = -1; t_ack = -1; gok = 1'b1;
    while (t < 200) begin
      tick();
      t++;
      if (sidle[0] && t_idle < 0) t_idle = t;
      if (ack0_a) begin
        t_ack = t;
        break;
      end
      if (grant_a != 2'b01) gok = 1'b0;
    end
    req0 = 1'b0;
    chk("t1_ack_lat", t_ack, 65);
    chk("t1_idle_to_ack", t_ack - t_idle, 1);
    chk("t1_grant_held", gok, 1);
    tick();
    chk("t1_acks", qa.size(), 1);
    chk("t1_ack_ch", (qa.size() > 0) ? qa[0] : 9, 0);
    chk("t1_back_idle", {busy_a, grant_a}, 0);

    // both requesting and held: round-robin vs fixed priority
    do_reset();
    shift_len = 4;
    data0 = WA;
    data1 = WB;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 300 && (qa.size() < 3 || qb.size() < 3); k++) tick();
    req0 = 1'b0;
    req1 = 1'b0;
    chk("t2_rr_n", qa.size() >= 3, 1);
    chk("t2_fix_n", qb.size() >= 3, 1);
    if (qa.size() >= 3 && qb.size() >= 3) begin
      chk("t2_rr_order", {qa[0][1:0], qa[1][1:0], qa[2][1:0]}, 6'b00_01_00);
      chk("t2_fix_order", {qb[0][1:0], qb[1][1:0], qb[2][1:0]}, 6'b00_00_00);
    end

    // serializer never leaves idle: timeout, then a successful retry
    do_reset();
    shift_len = 4;
    respond = 1'b0;
    data0 = WC;
    req0 = 1'b1;
    tick();
    chk("t3_grant", grant_a, 2'b01);
    t = 0;
    while (t < 100 && !err_a) begin
      tick();
      t++;
    end
    respond = 1'b1;
    chk("t3_err_lat", t, 16);
    chk("t3_no_ack", qa.size(), 0);
    chk("t3_grant_clr", grant_a, 2'b00);
    t = 0;
    while (t < 100 && !ack0_a) begin
      tick();
      t++;
    end
    req0 = 1'b0;
    tick();
    chk("t3_retry_ack", qa.size(), 1);

    // reset while the serializer is shifting aborts the transfer
    do_reset();
    shift_len = 64;
    data0 = WB;
    req0 = 1'b1;
    repeat (11) tick();
    chk("t4_busy_pre", busy_a, 1);
    req0 = 1'b0;
    rst = 1'b1;
    tick();
    chk("t4_ctl", {ack0_a, ack1_a, p2s_start_a, grant_a, busy_a, err_a}, 0);
    chk("t4_data", p2s_data_a, 0);
    rst = 1'b0;
    nack = 0;
    repeat (100) begin
      tick();
      if (ack0_a || ack1_a) nack++;
    end
    chk("t4_no_ack", nack, 0);

    // data changes during a transfer are ignored until the next grant
    do_reset();
    shift_len = 8;
    data0 = WA;
    req0 = 1'b1;
    tick();
    chk("t5_grant_data", p2s_data_a, WA);
    data0 = WC;
    repeat (4) tick();
    chk("t5_mid_data", p2s_data_a, WA);
    t = 0;
    while (t < 100 && !ack0_a) begin
      tick();
      t++;
    end
    req0 = 1'b0;
    tick();
    chk("t5_hold_data", p2s_data_a, WA);
    req0 = 1'b1;
    t = 0;
    while (t < 10 && grant_a != 2'b01) begin
      tick();
      t++;
    end
    chk("t5_new_data", p2s_data_a, WC);
    req0 = 1'b0;

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
